// File: rtl/mips32_fetch_queue.sv
// Purpose : MIPS32 instruction prefetch queue. Streams words from the instruction
//           memory into a DEPTH-entry FIFO of {ir, npc}, which feeds decode.
// Latency : the first word reaches decode 2 cycles after reset or redirect, then
//           1 word/cycle.
// Backpressure: a queue slot is reserved when a request is issued, so requests stop
//           once occupancy + in-flight reaches DEPTH and the queue cannot overflow.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   imem_req_valid/ready/addr        fetch request (10-bit word address = pc[9:0])
//   imem_rsp_valid/data              read data, returned exactly 1 cycle after acceptance
//   id_valid/ready, id_ir, id_npc    queue head presented to decode
//   redirect_valid/pc                taken branch: flush, refetch from redirect_pc
//   halted                           an HLT word (opcode 6'b111111) has been enqueued
//   q_count                          queue occupancy
module mips32_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [9:0]  imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        halted,
  output logic [3:0]  q_count
);

  localparam int         AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] W_DEPTH = 4'(DEPTH);

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] npc;
  } entry_t;

  entry_t        r_q [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [3:0]    r_count;
  logic [31:0]   r_pc;
  logic [31:0]   r_req_pc;    // pc of the request whose response is due this cycle
  logic          r_inflight;  // a request was accepted last cycle
  logic          r_discard;   // any response arriving this cycle belongs to a flushed stream
  logic          r_halted;

  logic [3:0]    w_occ;
  logic          w_req_fire;
  logic          w_enq;
  logic          w_deq;
  logic          w_hlt;

  // Occupancy counts the slot reserved by the outstanding request.
  assign w_occ          = r_count + {3'b000, r_inflight};
  assign imem_req_valid = !r_halted && !redirect_valid && !rst && (w_occ < W_DEPTH);
  assign imem_req_addr  = r_pc[9:0];
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign id_valid = (r_count != 4'd0) && !redirect_valid && !rst;
  assign id_ir    = r_q[r_rd].ir;
  assign id_npc   = r_q[r_rd].npc;
  assign w_deq    = id_valid && id_ready;

  // Once halted, anything still coming back from memory is past the HLT and dropped.
  assign w_enq = imem_rsp_valid && r_inflight && !r_discard && !r_halted
                 && !redirect_valid && !rst;
  assign w_hlt = w_enq && (imem_rsp_data[31:26] == 6'b111111);

  assign halted  = r_halted;
  assign q_count = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc       <= RESET_PC;
      r_req_pc   <= RESET_PC;
      r_count    <= 4'd0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b0;
      r_halted   <= 1'b0;
      r_rd       <= '0;
      r_wr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect beats any same-cycle response, dequeue or HLT. No request is issued
      // this cycle, so anything returning next cycle is stale.
      r_pc       <= redirect_pc;
      r_count    <= 4'd0;
      r_rd       <= '0;
      r_wr       <= '0;
      r_halted   <= 1'b0;
      r_inflight <= 1'b0;
      r_discard  <= 1'b1;
    end else begin
      r_inflight <= w_req_fire;
      r_discard  <= 1'b0;
      if (w_req_fire) begin
        r_pc     <= r_pc + 32'd1;
        r_req_pc <= r_pc;
      end
      if (w_enq) begin
        r_q[r_wr] <= '{ir: imem_rsp_data, npc: r_req_pc + 32'd1};
        r_wr      <= r_wr + 1'b1;
      end
      if (w_deq) begin
        r_rd <= r_rd + 1'b1;
      end
      r_count <= r_count + {3'b000, w_enq} - {3'b000, w_deq};
      if (w_hlt) begin
        r_halted <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Purpose : directed bench for mips32_fetch_queue with a transaction-level model.
// Latency : n/a (bench).
// Backpressure: drives memory ready / decode ready patterns from directed scenarios.
module tb_mips32_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;
  localparam logic [31:0] HLT_WORD = 32'hfc000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [9:0]  imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'd0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [31:0] id_ir;
  logic [31:0] id_npc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        halted;
  logic [3:0]  q_count;

  mips32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .id_valid(id_valid), .id_ready(id_ready), .id_ir(id_ir), .id_npc(id_npc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halted(halted), .q_count(q_count)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- model: expected occupancy, pc and delivery address ----------------
  bit          m_known = 1'b0;
  int          m_count;
  bit          m_inflight;
  bit          m_halted;
  logic [31:0] m_pc;
  logic [31:0] ea;        // word address decode must receive next
  logic [9:0]  m_raddr;   // address of the response due this cycle
  bit          exp_rv, exp_iv, m_deq, m_fire, m_keep;

  always @(negedge clk) begin
    #2;
    if (m_known) begin
      exp_rv = !m_halted && !redirect_valid && !rst && (m_count + int'(m_inflight) < DEPTH);
      exp_iv = (m_count != 0) && !redirect_valid && !rst;
      chk("req_valid", 32'(imem_req_valid), 32'(exp_rv));
      chk("req_addr", 32'(imem_req_addr), 32'(m_pc[9:0]));
      chk("q_count", 32'(q_count), 32'(m_count));
      chk("id_valid", 32'(id_valid), 32'(exp_iv));
      chk("halted", 32'(halted), 32'(m_halted));
      if (exp_iv && id_ready) begin
        chk("id_ir", id_ir, mem[ea[9:0]]);
        chk("id_npc", id_npc, ea + 32'd1);
      end
    end
    if (rst) begin
      m_known = 1'b1; m_pc = RESET_PC; ea = RESET_PC;
      m_count = 0; m_inflight = 1'b0; m_halted = 1'b0;
    end else if (m_known) begin
      if (redirect_valid) begin
        m_pc = redirect_pc; ea = redirect_pc;
        m_count = 0; m_inflight = 1'b0; m_halted = 1'b0;
      end else begin
        m_deq  = exp_iv && id_ready;
        m_fire = exp_rv && imem_req_ready;
        m_keep = m_inflight && !m_halted;
        if (m_keep && mem[m_raddr][31:26] == 6'b111111) m_halted = 1'b1;
        m_count = m_count + int'(m_keep) - int'(m_deq);
        if (m_fire) begin
          m_raddr = m_pc[9:0];
          m_pc    = m_pc + 32'd1;
        end
        m_inflight = m_fire;
        if (m_deq) ea = ea + 32'd1;
      end
    end
  end

  // ---------------- stimulus: memory responder + directed cycles ----------------
  bit          pend_v = 1'b0;
  logic [9:0]  pend_a = 10'd0;
  logic [31:0] log_ir[$];
  logic [31:0] log_npc[$];
  logic [3:0]  s_qc;
  logic        s_iv, s_rv, s_halted;

  task automatic cyc(input bit r, input bit rd, input logic [31:0] rpc,
                     input bit mr, input bit dr);
    @(negedge clk);
    rst = r; redirect_valid = rd; redirect_pc = rpc;
    imem_req_ready = mr; id_ready = dr;
    imem_rsp_valid = pend_v; imem_rsp_data = pend_v ? mem[pend_a] : 32'hdeadbeef;
    #1;
    pend_v = imem_req_valid && imem_req_ready;
    pend_a = imem_req_addr;
    s_qc = q_count; s_iv = id_valid; s_rv = imem_req_valid; s_halted = halted;
    if (id_valid && id_ready) begin
      log_ir.push_back(id_ir);
      log_npc.push_back(id_npc);
    end
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk("rst_q_count", 32'(s_qc), 32'd0);
    chk("rst_id_valid", 32'(s_iv), 32'd0);
    chk("rst_req_valid", 32'(s_rv), 32'd0);
    chk("rst_id_ir", id_ir, 32'd0);
    chk("rst_id_npc", id_npc, 32'd0);
    log_ir.delete();
    log_npc.delete();
  endtask

  int first_k;

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h20000000 | 32'(i);

    // Streaming: first word at cycle 2, then one per cycle.
    do_reset();
    first_k = -1;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 1, 1);
      if (first_k < 0 && s_iv) first_k = k;
    end
    chk("s1_first_cycle", 32'(first_k), 32'd2);
    chk("s1_count", 32'(log_ir.size()), 32'd8);
    chk("s1_npc0", log_npc[0], 32'd1);
    chk("s1_npc7", log_npc[7], 32'd8);
    chk("s1_ir5", log_ir[5], 32'h20000005);

    // Backpressure, including enqueue+dequeue at occupancy DEPTH-1.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 0, 0, 1, 1);
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0, 1, 0);
      if (k == 0) chk("s2_enq_deq_full", 32'(s_qc), 32'd3);
    end
    chk("s2_saturate", 32'(s_qc), 32'd4);
    chk("s2_no_req", 32'(s_rv), 32'd0);
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 1);
    chk("s2_npc0", log_npc[0], 32'd1);
    chk("s2_npc1", log_npc[1], 32'd2);
    chk("s2_ir4", log_ir[4], 32'h20000004);

    // Redirect with 3 queued and 1 in flight.
    do_reset();
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 0);
    cyc(0, 1, 32'd5, 1, 0);
    chk("s3_pre_count", 32'(s_qc), 32'd3);
    log_ir.delete(); log_npc.delete();
    cyc(0, 0, 0, 1, 1);
    chk("s3_flushed", 32'(s_qc), 32'd0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1);
    chk("s3_ir", log_ir[0], 32'h20000005);
    chk("s3_npc", log_npc[0], 32'd6);

    // Halt on HLT at word 3.
    mem[3] = HLT_WORD;
    do_reset();
    for (int k = 0; k < 12; k++) cyc(0, 0, 0, 1, 1);
    chk("s4_delivered", 32'(log_ir.size()), 32'd4);
    chk("s4_hlt_ir", log_ir[3], HLT_WORD);
    chk("s4_halted", 32'(s_halted), 32'd1);
    chk("s4_no_req", 32'(s_rv), 32'd0);

    // Redirect to 0 while HLT sits in a full queue.
    do_reset();
    for (int k = 0; k < 8; k++) cyc(0, 0, 0, 1, 0);
    chk("s5_halted", 32'(s_halted), 32'd1);
    chk("s5_full", 32'(s_qc), 32'd4);
    cyc(0, 1, 32'd0, 1, 0);
    log_ir.delete(); log_npc.delete();
    cyc(0, 0, 0, 1, 0);
    chk("s5_unhalted", 32'(s_halted), 32'd0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1);
    chk("s5_ir0", log_ir[0], 32'h20000000);
    chk("s5_npc0", log_npc[0], 32'd1);
    mem[3] = 32'h20000003;

    // Memory stall pattern, then reset mid-stream.
    do_reset();
    for (int k = 0; k < 24; k++) cyc(0, 0, 0, (k % 2) == 0, 1);
    chk("s6_some", 32'(log_npc.size() >= 8), 32'd1);
    for (int i = 0; i < log_npc.size(); i++) chk("s6_contig", log_npc[i], 32'(i + 1));
    cyc(1, 0, 0, 1, 1);
    log_ir.delete(); log_npc.delete();
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1);
    chk("s6_restart_npc", log_npc[0], RESET_PC + 32'd1);

    // Back-to-back redirects keep the last target.
    cyc(0, 1, 32'd10, 1, 1);
    cyc(0, 1, 32'd20, 1, 1);
    log_ir.delete(); log_npc.delete();
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 1, 1);
    chk("s7_last_target", log_npc[0], 32'd21);

    // pc wrap at 2^32 and address wrap at 1024 words.
    cyc(0, 1, 32'hfffffffe, 1, 1);
    log_ir.delete(); log_npc.delete();
    for (int k = 0; k < 6; k++) cyc(0, 0, 0, 1, 1);
    chk("s8_npc_wrap", log_npc[1], 32'd0);
    chk("s8_ir_1023", log_ir[1], 32'h200003ff);
    chk("s8_ir_0", log_ir[2], 32'h20000000);

    @(negedge clk);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips32_fetch_queue.md
MIPS32_FETCH_QUEUE -- requirements
Module: mips32_fetch_queue

Interface
REQ-001 The block SHALL use parameter DEPTH, default 4, as the number of prefetch queue entries (power of two, 2..8).
REQ-002 The block SHALL use parameter RESET_PC, default 32'd0, as the word address fetched first after reset.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 imem_req_valid  out  1  fetch request to instruction memory.
REQ-006 imem_req_ready  in  1  memory accepts the request this cycle.
REQ-007 imem_req_addr  out  10  word address, equal to pc[9:0].
REQ-008 imem_rsp_valid  in  1  read data valid, asserted exactly 1 cycle after each accepted request, in order.
REQ-009 imem_rsp_data  in  32  instruction word.
REQ-010 id_valid  out  1  queue head is presented to decode.
REQ-011 id_ready  in  1  decode accepts the head.
REQ-012 id_ir  out  32  head instruction word.
REQ-013 id_npc  out  32  head word address + 1.
REQ-014 redirect_valid  in  1  taken branch from EX/MEM; flush and refetch.
REQ-015 redirect_pc  in  32  branch target word address.
REQ-016 halted  out  1  HLT (opcode 6'b111111) has been fetched.
REQ-017 q_count  out  4  current queue occupancy.

Function
REQ-018 Queue entries SHALL be FIFO {ir, npc}; the head drives id_ir/id_npc, registered.
REQ-019 id_valid SHALL equal (q_count != 0) && !redirect_valid; a transfer occurs when id_valid && id_ready.
REQ-020 imem_req_valid SHALL equal !halted && !redirect_valid && !rst && (q_count + inflight < DEPTH), where inflight is 1 if a request was accepted last cycle.
REQ-021 On request acceptance (valid && ready), pc SHALL increment by 1; pc SHALL wrap modulo 2^32; the address SHALL wrap at 1024 words.
REQ-022 A response SHALL always be enqueued, with npc = request pc + 1, unless it is marked for discard; the slot is reserved at issue, so overflow SHALL be impossible.
REQ-023 Enqueue and dequeue in the same cycle SHALL leave q_count unchanged, including when q_count = DEPTH-1 or 1.
REQ-024 Throughput SHALL be 1 instruction/cycle when memory is always ready and decode is always ready; first id_valid SHALL occur 2 cycles after reset release.
REQ-025 When an enqueued word has opcode [31:26] = 6'b111111, it SHALL be enqueued, halted SHALL set the next cycle, and later responses SHALL be discarded.
REQ-026 redirect_valid SHALL flush the queue (q_count <- 0), set pc <- redirect_pc, clear halted, and mark the in-flight response (if any) for discard.
REQ-027 Redirect SHALL win over a simultaneous response, dequeue, or HLT detection.
REQ-028 The first request to redirect_pc SHALL be issued the cycle after redirect_valid.
REQ-029 A redirect asserted on consecutive cycles SHALL take the last target.
REQ-030 Halt SHALL persist until redirect or reset; queued entries, including HLT, SHALL still drain to decode.

Reset
REQ-031 rst SHALL set pc <- RESET_PC, q_count <- 0, inflight <- 0, discard <- 0, halted <- 0.
REQ-032 rst SHALL force imem_req_valid <- 0, id_valid <- 0, id_ir <- 0, id_npc <- 0.
REQ-033 rst mid-operation SHALL discard any response arriving in the following cycle.

Verification
REQ-034 Streaming: memory preloaded with words 0..7, always ready, id_ready = 1 -> id_ir = Mem[0..7] on consecutive cycles, id_npc = 1..8, first at cycle 2.
REQ-035 Backpressure: id_ready = 0 for 10 cycles -> q_count saturates at 4, imem_req_valid = 0, no loss; release -> words in order, no duplicates.
REQ-036 Redirect: redirect_valid pulsed with redirect_pc = 5 while the queue holds 3 entries and 1 is in flight -> q_count = 0 next cycle, next id_ir = Mem[5], id_npc = 6.
REQ-037 Halt: Mem[3] = 32'hfc000000 -> id_ir sequence Mem[0..3], halted = 1, no request issued after HLT detection, Mem[4] is never delivered.
REQ-038 Redirect with HLT in queue: redirect_pc = 0 -> halted clears, fetch resumes from word 0.
REQ-039 Memory stall: imem_req_ready toggling 1/0 -> delivered addresses contiguous, no gaps or repeats; rst mid-stream -> restart at RESET_PC.
